// File: rtl/wbm_if.sv
// Write-back stage bus: lsm result in, decode issue/operand handshake, register-file write out.
// Forwarding ports exist only when WBM_FORWARD_EN is defined.
interface wbm_if;
  logic        input_valid_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic        issue_valid_i;
  logic        issue_write_i;
  logic [4:0]  issue_addr_i;
  logic        issue_ready_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;
  logic        rf_write_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
`ifdef WBM_FORWARD_EN
  logic        fwd_rs1_valid_o;
  logic        fwd_rs2_valid_o;
  logic [31:0] fwd_rs1_data_o;
  logic [31:0] fwd_rs2_data_o;
`endif

  modport slave (
    input  input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
    input  issue_valid_i, issue_write_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
    output issue_ready_o, hazard_o, rf_write_o, rf_addr_o, rf_data_o
`ifdef WBM_FORWARD_EN
    , output fwd_rs1_valid_o, fwd_rs2_valid_o, fwd_rs1_data_o, fwd_rs2_data_o
`endif
  );

  modport master (
    output input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
    output issue_valid_i, issue_write_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
    input  issue_ready_o, hazard_o, rf_write_o, rf_addr_o, rf_data_o
`ifdef WBM_FORWARD_EN
    , input fwd_rs1_valid_o, fwd_rs2_valid_o, fwd_rs1_data_o, fwd_rs2_data_o
`endif
  );
endinterface

// File: rtl/wbm.sv
// Write-back stage: registered RF write port, retired counter and per-register in-flight scoreboard.
// Define WBM_FORWARD_EN to add operand forwarding from the RF write port.
module wbm #(
  parameter int INSTRET_W = 64,
  parameter int CNT_W     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wbm_if.slave                 bus,
  output logic [INSTRET_W-1:0] instret_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 rf_write_q, rf_write_d;
  logic [4:0]           rf_addr_q,  rf_addr_d;
  logic [31:0]          rf_data_q,  rf_data_d;
  logic [INSTRET_W-1:0] instret_q,  instret_d;
  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W-1:0] iss_cnt, rs1_cnt, rs2_cnt;
  logic             issue_ready, issue_inc;
  logic [31:0]      inc_vec, dec_vec;

  // cnt_q[0] is held at zero, so x0 lookups need no special case
  assign iss_cnt = cnt_q[bus.issue_addr_i];
  assign rs1_cnt = cnt_q[bus.rs1_addr_i];
  assign rs2_cnt = cnt_q[bus.rs2_addr_i];

  assign issue_ready = !(bus.issue_write_i && (bus.issue_addr_i != 5'd0) && (iss_cnt == CNT_MAX));
  assign issue_inc   = bus.issue_valid_i && issue_ready && bus.issue_write_i &&
                       (bus.issue_addr_i != 5'd0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_inc)  inc_vec[bus.issue_addr_i] = 1'b1;
    if (rf_write_q) dec_vec[rf_addr_q]        = 1'b1;
  end

  // inc and dec on one register cancel; a stray dec on zero is absorbed
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < 32; r++) begin
      if (inc_vec[r] && !dec_vec[r])
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0))
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    rf_write_d = bus.input_valid_i && bus.reg_write_i && (bus.reg_addr_i != 5'd0);
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (bus.input_valid_i) begin
      rf_addr_d = bus.reg_addr_i;
      rf_data_d = bus.reg_data_i;
    end
    instret_d = instret_q + INSTRET_W'(bus.input_valid_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      instret_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      instret_q  <= instret_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef WBM_FORWARD_EN
  logic fwd1, fwd2;
  // only the last outstanding write may be forwarded; older ones would be stale
  assign fwd1 = rf_write_q && (bus.rs1_addr_i == rf_addr_q) && (bus.rs1_addr_i != 5'd0) &&
                (rs1_cnt == CNT_W'(1));
  assign fwd2 = rf_write_q && (bus.rs2_addr_i == rf_addr_q) && (bus.rs2_addr_i != 5'd0) &&
                (rs2_cnt == CNT_W'(1));
  assign bus.fwd_rs1_valid_o = fwd1;
  assign bus.fwd_rs2_valid_o = fwd2;
  assign bus.fwd_rs1_data_o  = rf_data_q;
  assign bus.fwd_rs2_data_o  = rf_data_q;
  assign bus.hazard_o = ((bus.rs1_addr_i != 5'd0) && (rs1_cnt != '0) && !fwd1) ||
                        ((bus.rs2_addr_i != 5'd0) && (rs2_cnt != '0) && !fwd2);
`else
  assign bus.hazard_o = ((bus.rs1_addr_i != 5'd0) && (rs1_cnt != '0)) ||
                        ((bus.rs2_addr_i != 5'd0) && (rs2_cnt != '0));
`endif

  assign bus.issue_ready_o = issue_ready;
  assign bus.rf_write_o    = rf_write_q;
  assign bus.rf_addr_o     = rf_addr_q;
  assign bus.rf_data_o     = rf_data_q;
  assign instret_o         = instret_q;
endmodule
